// File: rtl/pipe_mux_nw.sv
// Pipelined N:1 lane selector: stage 1 picks within groups, stage 2 picks the group.
// Optional parity output/check enabled by defining PIPE_MUX_PARITY_EN.
module pipe_mux_nw #(
  parameter  int NUM_IN = 64,
  parameter  int DATA_W = 1,
  parameter  int GROUP  = 8,
  localparam int SEL_W  = $clog2(NUM_IN)
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [NUM_IN*DATA_W-1:0] in_data,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic                     mode,
  input  logic [SEL_W-1:0]         sel,
  output logic [DATA_W-1:0]        out_data,
  output logic [SEL_W-1:0]         out_sel,
  output logic                     sel_err,
  output logic                     out_valid,
  input  logic                     out_ready
`ifdef PIPE_MUX_PARITY_EN
  ,
  input  logic                     in_par_chk,
  output logic                     out_parity
`endif
);

  localparam int NUM_GRP = NUM_IN / GROUP;
  localparam int GB      = $clog2(GROUP);
  localparam logic [SEL_W:0]   NUM_IN_L = (SEL_W+1)'(NUM_IN);
  localparam logic [SEL_W-1:0] LAST_SEL = SEL_W'(NUM_IN - 1);

  logic [DATA_W-1:0] lane [NUM_GRP][GROUP];

  for (genvar g = 0; g < NUM_GRP; g++) begin : g_grp
    for (genvar l = 0; l < GROUP; l++) begin : g_lane
      assign lane[g][l] = in_data[(g*GROUP + l)*DATA_W +: DATA_W];
    end
  end

  logic [SEL_W-1:0] scan_cnt;
  logic [SEL_W-1:0] eff_sel;
  logic [GB-1:0]    lo_sel;
  logic             accept;
  logic             s2_ready;
  logic             adv;
  logic             vld_p1;

  assign eff_sel  = mode ? scan_cnt : sel;
  assign lo_sel   = eff_sel[GB-1:0];
  assign s2_ready = !out_valid || out_ready;
  assign in_ready = !vld_p1 || s2_ready;
  assign accept   = in_valid && in_ready;
  assign adv      = vld_p1 && s2_ready;

  // ---- stage 1: one candidate per group, captured select and range flag ----
  logic [DATA_W-1:0] grp_p1 [NUM_GRP];
  logic [SEL_W-1:0]  sel_p1;
  logic              err_p1;

  always_ff @(posedge clk) begin
    if (accept) begin
      for (int g = 0; g < NUM_GRP; g++) begin
        grp_p1[g] <= lane[g][lo_sel];
      end
      sel_p1 <= eff_sel;
      err_p1 <= ({1'b0, eff_sel} >= NUM_IN_L);
    end
  end

  // ---- stage 2: group pick; compare-based so an out-of-range index selects nothing ----
  logic [DATA_W-1:0] grp_pick;
  logic [DATA_W-1:0] data_p2;
  logic              err_p2;

  always_comb begin
    grp_pick = '0;
    for (int g = 0; g < NUM_GRP; g++) begin
      if ((int'(sel_p1) >> GB) == g) grp_pick = grp_p1[g];
    end
    data_p2 = err_p1 ? '0 : grp_pick;
`ifdef PIPE_MUX_PARITY_EN
    err_p2  = err_p1 | (in_par_chk & (^data_p2));
`else
    err_p2  = err_p1;
`endif
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      vld_p1    <= 1'b0;
      out_valid <= 1'b0;
      out_data  <= '0;
      out_sel   <= '0;
      sel_err   <= 1'b0;
      scan_cnt  <= '0;
`ifdef PIPE_MUX_PARITY_EN
      out_parity <= 1'b0;
`endif
    end else begin
      if (accept)   vld_p1 <= 1'b1;
      else if (adv) vld_p1 <= 1'b0;

      if (adv) begin
        out_valid <= 1'b1;
        out_data  <= data_p2;
        out_sel   <= sel_p1;
        sel_err   <= err_p2;
`ifdef PIPE_MUX_PARITY_EN
        out_parity <= ^data_p2;
`endif
      end else if (out_ready) begin
        out_valid <= 1'b0;
      end

      if (accept && mode) begin
        scan_cnt <= (scan_cnt == LAST_SEL) ? '0 : scan_cnt + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_pipe_mux_nw.sv
// Bench for pipe_mux_nw: two instances (64 and 48 lanes) driven by shared controls,
// checked against a queue-based reference model plus table-driven sequences.
module tb_pipe_mux_nw;
  localparam int DW = 8;
  localparam int NA = 64;
  localparam int NB = 48;
  localparam int SW = 6;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic             rst_n, in_valid, mode, out_ready, par_chk;
  logic [SW-1:0]    sel;
  logic [NA*DW-1:0] data_a;
  logic [NB*DW-1:0] data_b;
  logic             rdy_a, rdy_b, ov_a, ov_b, err_a, err_b;
  logic [DW-1:0]    od_a, od_b;
  logic [SW-1:0]    os_a, os_b;
`ifdef PIPE_MUX_PARITY_EN
  logic             par_a, par_b;
`endif

  pipe_mux_nw #(.NUM_IN(NA), .DATA_W(DW), .GROUP(8)) dut_a (
    .clk(clk), .rst_n(rst_n), .in_data(data_a), .in_valid(in_valid), .in_ready(rdy_a),
    .mode(mode), .sel(sel), .out_data(od_a), .out_sel(os_a), .sel_err(err_a),
    .out_valid(ov_a), .out_ready(out_ready)
`ifdef PIPE_MUX_PARITY_EN
    , .in_par_chk(par_chk), .out_parity(par_a)
`endif
  );

  pipe_mux_nw #(.NUM_IN(NB), .DATA_W(DW), .GROUP(8)) dut_b (
    .clk(clk), .rst_n(rst_n), .in_data(data_b), .in_valid(in_valid), .in_ready(rdy_b),
    .mode(mode), .sel(sel), .out_data(od_b), .out_sel(os_b), .sel_err(err_b),
    .out_valid(ov_b), .out_ready(out_ready)
`ifdef PIPE_MUX_PARITY_EN
    , .in_par_chk(par_chk), .out_parity(par_b)
`endif
  );

  typedef struct {
    logic [DW-1:0] d;
    logic [SW-1:0] s;
    logic          e;
    logic          p;
    int            t;
  } item_t;

  typedef struct {
    logic [SW-1:0] sel;
    logic [DW-1:0] exp_a;
    logic [DW-1:0] exp_b;
    logic          err_b;
  } vec_t;

  item_t qa[$], qb[$], got_a[$], got_b[$];
  int    tests = 0, fails = 0, cyc = 0, acc_n = 0;
  int    scan_a = 0, scan_b = 0;

  task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // Expected beat from the rules: lane value if in range, else zero with error.
  function automatic item_t predict(int n, logic [NA*DW-1:0] d, int s, logic pc);
    item_t it;
    it.s = s[SW-1:0];
    it.t = cyc;
    if (s >= n) begin
      it.d = '0;
      it.e = 1'b1;
    end else begin
      it.d = d[s*DW +: DW];
      it.e = pc & (^it.d);
    end
    it.p = ^it.d;
    return it;
  endfunction

  task automatic step();
    logic             er, va, vb;
    logic [NA*DW-1:0] wide_b;
    item_t            h, g;
    #1;
    er = (qa.size() < 2) || out_ready;
    chk("in_ready_a", 32'(rdy_a), 32'(er));
    chk("in_ready_b", 32'(rdy_b), 32'(er));
    va = (qa.size() > 0) && (cyc - qa[0].t >= 2);
    vb = (qb.size() > 0) && (cyc - qb[0].t >= 2);
    chk("out_valid_a", 32'(ov_a), 32'(va));
    chk("out_valid_b", 32'(ov_b), 32'(vb));
    if (va) begin
      h = qa[0];
      chk("data_a", 32'(od_a), 32'(h.d));
      chk("sel_a", 32'(os_a), 32'(h.s));
      chk("err_a", 32'(err_a), 32'(h.e));
      g.d = od_a; g.s = os_a; g.e = err_a; g.p = 1'b0; g.t = cyc;
`ifdef PIPE_MUX_PARITY_EN
      chk("parity_a", 32'(par_a), 32'(h.p));
      g.p = par_a;
`endif
      if (out_ready) begin
        void'(qa.pop_front());
        got_a.push_back(g);
      end
    end
    if (vb) begin
      h = qb[0];
      chk("data_b", 32'(od_b), 32'(h.d));
      chk("sel_b", 32'(os_b), 32'(h.s));
      chk("err_b", 32'(err_b), 32'(h.e));
      g.d = od_b; g.s = os_b; g.e = err_b; g.p = 1'b0; g.t = cyc;
`ifdef PIPE_MUX_PARITY_EN
      chk("parity_b", 32'(par_b), 32'(h.p));
      g.p = par_b;
`endif
      if (out_ready) begin
        void'(qb.pop_front());
        got_b.push_back(g);
      end
    end
    if (in_valid && er) begin
      acc_n++;
      wide_b = '0;
      wide_b[NB*DW-1:0] = data_b;
      qa.push_back(predict(NA, data_a, mode ? scan_a : int'(sel), par_chk));
      qb.push_back(predict(NB, wide_b, mode ? scan_b : int'(sel), par_chk));
      if (mode) begin
        scan_a = (scan_a + 1) % NA;
        scan_b = (scan_b + 1) % NB;
      end
    end
    @(posedge clk);
    cyc++;
    if (!rst_n) begin
      qa.delete(); qb.delete();
      scan_a = 0; scan_b = 0;
    end
    @(negedge clk);
  endtask

  task automatic drive(logic v, logic m, logic [SW-1:0] s, logic r);
    in_valid = v; mode = m; sel = s; out_ready = r;
  endtask

  task automatic drain();
    in_valid  = 1'b0;
    out_ready = 1'b1;
    for (int i = 0; i < 20 && (qa.size() > 0 || qb.size() > 0); i++) step();
    chk("drain_empty", 32'(qa.size() + qb.size()), 32'd0);
  endtask

  task automatic reset_state_check(string tag);
    out_ready = 1'b0;
    #1;
    chk({tag, "_out_valid"}, 32'({ov_a, ov_b}), 32'd0);
    chk({tag, "_out_data"}, 32'({od_a, od_b}), 32'd0);
    chk({tag, "_out_sel"}, 32'({os_a, os_b}), 32'd0);
    chk({tag, "_sel_err"}, 32'({err_a, err_b}), 32'd0);
    chk({tag, "_in_ready"}, 32'({rdy_a, rdy_b}), 32'b11);
  endtask

  task automatic set_pattern(logic [DW-1:0] ka, logic [DW-1:0] kb);
    for (int i = 0; i < NA; i++) data_a[i*DW +: DW] = DW'(i) ^ ka;
    for (int i = 0; i < NB; i++) data_b[i*DW +: DW] = DW'(i) ^ kb;
  endtask

  task automatic randomize_data();
    for (int w = 0; w < NA*DW/32; w++) data_a[w*32 +: 32] = $urandom();
    for (int w = 0; w < NB*DW/32; w++) data_b[w*32 +: 32] = $urandom();
  endtask

  vec_t          vec[6];
  logic [SW-1:0] bp_exp[6];

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    vec[0] = '{6'd0,  8'hA5, 8'h3C, 1'b0};
    vec[1] = '{6'd7,  8'hA2, 8'h3B, 1'b0};
    vec[2] = '{6'd8,  8'hAD, 8'h34, 1'b0};
    vec[3] = '{6'd63, 8'h9A, 8'h00, 1'b1};
    vec[4] = '{6'd50, 8'h97, 8'h00, 1'b1};
    vec[5] = '{6'd47, 8'h8A, 8'h13, 1'b0};
    bp_exp = '{6'd10, 6'd11, 6'd20, 6'd21, 6'd22, 6'd23};

    par_chk = 1'b0;
    set_pattern(8'hA5, 8'h3C);
    rst_n = 1'b0;
    drive(1'b1, 1'b0, '0, 1'b0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n    = 1'b1;
    in_valid = 1'b0;
    reset_state_check("reset");

    // Direct-mode vectors, back-to-back, out_ready high
    got_a.delete(); got_b.delete();
    for (int i = 0; i < 6; i++) begin
      drive(1'b1, 1'b0, vec[i].sel, 1'b1);
      step();
    end
    drain();
    chk("vec_count", 32'(got_a.size()), 32'd6);
    for (int i = 0; i < 6 && i < got_a.size() && i < got_b.size(); i++) begin
      chk($sformatf("vec%0d_data_a", i), 32'(got_a[i].d), 32'(vec[i].exp_a));
      chk($sformatf("vec%0d_sel_a", i), 32'(got_a[i].s), 32'(vec[i].sel));
      chk($sformatf("vec%0d_data_b", i), 32'(got_b[i].d), 32'(vec[i].exp_b));
      chk($sformatf("vec%0d_err_b", i), 32'(got_b[i].e), 32'(vec[i].err_b));
      chk($sformatf("vec%0d_sel_b", i), 32'(got_b[i].s), 32'(vec[i].sel));
    end

    // Backpressure: 5 stalled cycles absorb only 2 beats, then release
    got_a.delete(); got_b.delete();
    acc_n = 0;
    for (int i = 0; i < 5; i++) begin
      drive(1'b1, 1'b0, SW'(10 + i), 1'b0);
      step();
    end
    chk("bp_accepts", 32'(acc_n), 32'd2);
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, 1'b0, SW'(20 + i), 1'b1);
      step();
    end
    drain();
    chk("bp_count", 32'(got_a.size()), 32'd6);
    for (int i = 0; i < 6 && i < got_a.size(); i++)
      chk($sformatf("bp%0d_sel", i), 32'(got_a[i].s), 32'(bp_exp[i]));

    // Scan mode from a fresh counter: 50 accepts, wrap at 48 on dut_b
    rst_n = 1'b0; step(); rst_n = 1'b1;
    got_a.delete(); got_b.delete();
    for (int i = 0; i < 50; i++) begin
      drive(1'b1, 1'b1, SW'($urandom_range(0, 63)), 1'b1);
      step();
    end
    drain();
    chk("scan_count", 32'(got_b.size()), 32'd50);
    for (int i = 0; i < 50 && i < got_b.size() && i < got_a.size(); i++) begin
      chk($sformatf("scan%0d_sel_b", i), 32'(got_b[i].s), 32'(i % NB));
      chk($sformatf("scan%0d_err_b", i), 32'(got_b[i].e), 32'd0);
      chk($sformatf("scan%0d_sel_a", i), 32'(got_a[i].s), 32'(i));
    end

    // Reset while beats are in flight, then scan restarts from lane 0
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, 1'b1, '0, 1'b0);
      step();
    end
    rst_n = 1'b0;
    step(); step();
    rst_n = 1'b1;
    in_valid = 1'b0;
    reset_state_check("midreset");
    got_a.delete(); got_b.delete();
    drive(1'b1, 1'b1, 6'd33, 1'b1);
    step();
    drain();
    chk("midreset_count", 32'(got_b.size()), 32'd1);
    if (got_b.size() > 0) chk("midreset_scan_sel", 32'(got_b[0].s), 32'd0);

    // Random traffic against the reference model
    for (int i = 0; i < 400; i++) begin
      randomize_data();
      rst_n = ($urandom_range(0, 99) != 0);
      drive(1'($urandom), ($urandom_range(0, 3) == 0), SW'($urandom), ($urandom_range(0, 3) != 0));
      step();
    end
    rst_n = 1'b1;
    drain();

`ifdef PIPE_MUX_PARITY_EN
    // Odd-parity lane with and without parity check
    for (int i = 0; i < NA; i++) data_a[i*DW +: DW] = 8'h07;
    for (int i = 0; i < NB; i++) data_b[i*DW +: DW] = 8'h07;
    for (int k = 0; k < 2; k++) begin
      par_chk = (k == 0);
      got_a.delete();
      drive(1'b1, 1'b0, 6'd5, 1'b1);
      step();
      drain();
      chk("par_count", 32'(got_a.size()), 32'd1);
      if (got_a.size() > 0) begin
        chk($sformatf("par%0d_parity", k), 32'(got_a[0].p), 32'd1);
        chk($sformatf("par%0d_err", k), 32'(got_a[0].e), 32'(k == 0));
        chk($sformatf("par%0d_data", k), 32'(got_a[0].d), 32'h07);
      end
    end
    par_chk = 1'b0;
`endif

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
